// File: rtl/seq_div16.sv
// seq_div16 -- sequential 16-bit unsigned restoring divider.
//
// Accepts a dividend/divisor pair over a valid/ready handshake, produces one
// quotient bit per clock (MSB first), then holds quotient, remainder and a
// divide-by-zero flag until the consumer takes them. Only one operation is
// in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   divider can accept operands (IDLE)
//   dd         dividend, unsigned 16 bit
//   dv         divisor, unsigned 16 bit
//   out_valid  result held on outputs (DONE)
//   out_ready  consumer accepts result
//   qq         quotient
//   rr         remainder (dd on divide-by-zero); tied to 0 unless DIV16_REM_EN
//   div0       divisor was zero for this result
//
// Build option:
//   DIV16_REM_EN  when defined, rr carries the remainder and its output
//                 register is built; when undefined, rr is constant zero.

module seq_div16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dd,
  input  logic [15:0] dv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] qq,
  output logic [15:0] rr,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after 16 steps this register holds the full quotient.
  logic [15:0] dsh;
  logic [15:0] dvr;
  logic [16:0] prem;
  logic [15:0] qq_r;
  logic        div0_r;
  logic [17:0] step;
  logic        qbit;
  logic [16:0] prem_nxt;

  // One restoring step: shift the next dividend bit in, subtract the divisor
  // if it fits. Returns {quotient bit, new partial remainder}.
  function automatic logic [17:0] div_step(input logic [16:0] pr,
                                           input logic        bit_in,
                                           input logic [15:0] d);
    logic [17:0] trial;
    logic [17:0] diff;
    trial = {pr, bit_in};
    diff  = trial - {2'b00, d};
    if (trial >= {2'b00, d})
      div_step = {1'b1, diff[16:0]};
    else
      div_step = {1'b0, trial[16:0]};
  endfunction

  assign step     = div_step(prem, dsh[15], dvr);
  assign qbit     = step[17];
  assign prem_nxt = step[16:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign qq        = qq_r;
  assign div0      = div0_r;

`ifdef DIV16_REM_EN
  logic [15:0] rr_r;
  assign rr = rr_r;
`else
  assign rr = 16'h0000;
`endif

  // Next-state logic. A zero divisor still spends one cycle in BUSY so that
  // both latencies are counted from the same acceptance edge (1 vs 16).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if ((dvr == 16'h0000) || (cnt == 4'd15)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      dsh    <= 16'h0000;
      dvr    <= 16'h0000;
      prem   <= 17'd0;
      qq_r   <= 16'h0000;
      div0_r <= 1'b0;
`ifdef DIV16_REM_EN
      rr_r   <= 16'h0000;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsh  <= dd;
            dvr  <= dv;
            cnt  <= 4'd0;
            prem <= 17'd0;
          end
        end
        BUSY: begin
          if (dvr == 16'h0000) begin
            qq_r   <= 16'hFFFF;
            div0_r <= 1'b1;
`ifdef DIV16_REM_EN
            rr_r   <= dsh;
`endif
          end else begin
            prem <= prem_nxt;
            dsh  <= {dsh[14:0], qbit};
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              qq_r   <= {dsh[14:0], qbit};
              div0_r <= 1'b0;
`ifdef DIV16_REM_EN
              rr_r   <= prem_nxt[15:0];
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: directed operations with hand-computed
// results, back-to-back issue, output stall, asynchronous reset mid-operation,
// and a short pseudo-random sweep against a division reference.

module tb_seq_div16;

`ifdef DIV16_REM_EN
  localparam bit REM = 1'b1;
`else
  localparam bit REM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dd;
  logic [15:0] dv;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] qq;
  logic [15:0] rr;
  logic        div0;

  int checks = 0;
  int errors = 0;

  seq_div16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dd        (dd),
    .dv        (dv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .qq        (qq),
    .rr        (rr),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rr(input logic [15:0] r);
    return REM ? r : 16'h0000;
  endfunction

  // Issue one operation, measure latency, optionally stall the consumer for
  // 'hold' cycles, then consume and check the handshake release.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic ez, input int hold);
    int lat;
    int wait_cnt;
    int exp_lat;
    exp_lat  = (b == 16'h0000) ? 1 : 16;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    dd = a;
    dv = b;
    @(posedge clk); #1;               // acceptance edge E0
    in_valid = 1'b0;
    dd = 16'h1234;                    // operands must be latched, not followed
    dv = 16'h0001;
    check("in_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) check("in_ready_busy", in_ready, 0);
    end
    check("latency", lat, exp_lat);
    check("qq", qq, eq);
    check("rr", rr, exp_rr(er));
    check("div0", div0, ez);
    check("in_ready_done", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_qq", qq, eq);
      check("hold_rr", rr, exp_rr(er));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;               // consume edge Ec
    out_ready = 1'b0;
    check("valid_after_consume", out_valid, 0);
    check("in_ready_after_consume", in_ready, 1);
    check("qq_kept", qq, eq);
    check("div0_kept", div0, ez);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dd        = 16'h0000;
    dv        = 16'h0000;
    rst_n     = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_qq", qq, 0);
    check("rst_rr", rr, 0);
    check("rst_div0", div0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 0);
    do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0);
    do_op(16'd3, 16'd9, 16'd0, 16'd3, 1'b0, 0);
    do_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);
    do_op(16'd10, 16'd2, 16'd5, 16'd0, 1'b0, 0);
    do_op(16'd40000, 16'd123, 16'd325, 16'd25, 1'b0, 5);

    // Asynchronous reset after step 8 of 50000/3.
    in_valid = 1'b1;
    dd = 16'd50000;
    dv = 16'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_qq", qq, 0);
    check("midrst_rr", rr, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'd50000, 16'd3, 16'd16666, 16'd2, 1'b0, 0);

    // Pseudo-random sweep covering dv=0, dd=0, dd<dv and dd=dv.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (i % 8)
        0: rb = 16'h0000;
        1: ra = 16'h0000;
        2: rb = (ra == 16'hFFFF) ? ra : ra + 16'd1 + 16'($urandom_range(0, 100));
        3: rb = ra;
        4: rb = 16'($urandom_range(1, 255));
        default: ;
      endcase
      if (rb == 16'h0000)
        do_op(ra, rb, 16'hFFFF, ra, 1'b1, 0);
      else
        do_op(ra, rb, ra / rb, ra % rb, 1'b0, i % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
